// File: rtl/joy_db15_tx.sv
// Device side of the DB15 joystick link: a synchronised 74HC165-style responder
// that answers host JOY_LOAD/JOY_CLK with an active-low 2*PLAYER_BITS frame.
module joy_db15_tx #(
  parameter int SYNC_STAGES = 2,
  parameter int PLAYER_BITS = 12
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [PLAYER_BITS-1:0] joy_p1,
  input  logic [PLAYER_BITS-1:0] joy_p2,
  input  logic                   JOY_CLK,
  input  logic                   JOY_LOAD,
  output logic                   JOY_DATA,
  output logic                   frame_done,
  output logic                   busy
);

  localparam int FRAME_BITS = 2 * PLAYER_BITS;
  localparam int CW         = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_BITS - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);

  logic [SYNC_STAGES-1:0] ck_sync;
  logic [SYNC_STAGES-1:0] ld_sync;
  logic                   ck_s;
  logic                   ck_prev;
  logic                   ck_rise;
  logic                   ld;
  logic [FRAME_BITS-1:0]  sr;
  logic [CW-1:0]          cnt;

  // Chains reset high so a host clock already high at release is not an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ck_sync <= '1;
      ld_sync <= '1;
    end else begin
      ck_sync <= {ck_sync[SYNC_STAGES-2:0], JOY_CLK};
      ld_sync <= {ld_sync[SYNC_STAGES-2:0], JOY_LOAD};
    end
  end

  assign ck_s = ck_sync[SYNC_STAGES-1];
  assign ld   = ld_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ck_prev <= 1'b1;
      ck_rise <= 1'b0;
    end else begin
      ck_prev <= ck_s;
      ck_rise <= ck_s & ~ck_prev;
    end
  end

  // Load is level-sensitive and swallows any coincident shift edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr  <= '1;
      cnt <= '0;
    end else if (!ld) begin
      sr  <= {~joy_p2, ~joy_p1};
      cnt <= '0;
    end else if (ck_rise) begin
      sr <= {1'b1, sr[FRAME_BITS-1:1]};
      if (cnt != CNT_FULL) cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_done <= ck_rise & ld & (cnt == CNT_LAST);
      busy       <= (cnt != '0) && (cnt != CNT_FULL);
    end
  end

  assign JOY_DATA = sr[0];

endmodule

// File: tb/tb_joy_db15_tx.sv
// Bench for joy_db15_tx: a host driver issues load/clock sequences and pushes
// expected wire bits and frame_done times; a monitor pops and compares them.
module tb_joy_db15_tx;

  localparam int SYNC_STAGES = 2;
  localparam int PLAYER_BITS = 12;
  localparam int FRAME_BITS  = 2 * PLAYER_BITS;
  localparam int HALF        = 8;

  logic                   clk;
  logic                   reset_n;
  logic [PLAYER_BITS-1:0] joy_p1;
  logic [PLAYER_BITS-1:0] joy_p2;
  logic                   JOY_CLK;
  logic                   JOY_LOAD;
  logic                   JOY_DATA;
  logic                   frame_done;
  logic                   busy;

  int n_tests;
  int n_fail;
  int cyc;
  int edges_since_load;
  logic load_low;
  logic sample_req;
  logic [FRAME_BITS-1:0] exp_frame;

  logic [0:0] exp_q[$];
  int         tag_q[$];
  int         fd_q[$];

  joy_db15_tx #(
    .SYNC_STAGES(SYNC_STAGES),
    .PLAYER_BITS(PLAYER_BITS)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .joy_p1     (joy_p1),
    .joy_p2     (joy_p2),
    .JOY_CLK    (JOY_CLK),
    .JOY_LOAD   (JOY_LOAD),
    .JOY_DATA   (JOY_DATA),
    .frame_done (frame_done),
    .busy       (busy)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (sample_req) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sample_underflow: got sample expected none");
      end else begin
        logic [0:0] e;
        int t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check($sformatf("wire_bit_%0d", t), 32'(JOY_DATA), 32'(e));
      end
    end
    if (frame_done) begin
      if (fd_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_frame_done: got pulse at cycle %0d expected none", cyc);
      end else begin
        check("frame_done_cycle", 32'(cyc), 32'(fd_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic sample_bit(input logic e, input int tag);
    @(posedge clk);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    sample_req = 1'b1;
    @(posedge clk);
    sample_req = 1'b0;
  endtask

  task automatic host_edge();
    @(negedge clk);
    JOY_CLK = 1'b1;
    if (!load_low) begin
      edges_since_load++;
      if (edges_since_load == FRAME_BITS) fd_q.push_back(cyc + SYNC_STAGES + 2);
    end
    repeat (HALF) @(negedge clk);
    JOY_CLK = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic host_load();
    @(negedge clk);
    JOY_LOAD = 1'b0;
    exp_frame = {~joy_p2, ~joy_p1};
    edges_since_load = 0;
    repeat (SYNC_STAGES + 4) @(negedge clk);
    JOY_LOAD = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  // Load, then n_clk (sample, clock) pairs and a final sample.
  task automatic run_frame(input int n_clk, input int change_at, input logic [PLAYER_BITS-1:0] new_p1);
    host_load();
    for (int i = 0; i < n_clk; i++) begin
      if (i == change_at) joy_p1 = new_p1;
      sample_bit((i < FRAME_BITS) ? exp_frame[i] : 1'b1, i);
      host_edge();
      if (i == 0) check("busy_after_first_shift", 32'(busy), 32'd1);
    end
    sample_bit((n_clk < FRAME_BITS) ? exp_frame[n_clk] : 1'b1, n_clk);
  endtask

  initial begin
    int bad;
    n_tests = 0;
    n_fail = 0;
    cyc = 0;
    edges_since_load = 0;
    load_low = 1'b0;
    sample_req = 1'b0;
    reset_n = 1'b0;
    JOY_CLK = 1'b0;
    JOY_LOAD = 1'b1;
    joy_p1 = 12'h001;
    joy_p2 = 12'h800;
    repeat (3) @(negedge clk);
    check("reset_joy_data", 32'(JOY_DATA), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_frame_done", 32'(frame_done), 32'd0);
    reset_n = 1'b1;

    // idle host
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (JOY_DATA !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("idle_bad_cycles", 32'(bad), 32'd0);

    // full frame: wire 0, 1x22, 0
    run_frame(FRAME_BITS, -1, 12'h000);
    check("busy_after_frame", 32'(busy), 32'd0);

    // input change after 3rd clock does not disturb the frame in flight
    joy_p1 = 12'h001;
    run_frame(FRAME_BITS, 3, 12'hFFF);

    // distinct pattern
    joy_p1 = 12'hA5C;
    joy_p2 = 12'h3F0;
    run_frame(FRAME_BITS, -1, 12'h000);

    // overrun: 30 clocks, bits beyond the frame are released
    joy_p1 = 12'h001;
    joy_p2 = 12'h800;
    run_frame(30, -1, 12'h000);
    check("busy_after_overrun", 32'(busy), 32'd0);

    // load held low while the host clock toggles
    @(negedge clk);
    JOY_LOAD = 1'b0;
    load_low = 1'b1;
    repeat (SYNC_STAGES + 4) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (i == 5) joy_p1 = 12'h000;
      host_edge();
      sample_bit(~joy_p1[0], 100 + i);
      check("busy_load_held", 32'(busy), 32'd0);
    end
    JOY_LOAD = 1'b1;
    load_low = 1'b0;
    repeat (HALF) @(negedge clk);

    // reset mid-frame after 10 shifts
    joy_p1 = 12'h6C3;
    joy_p2 = 12'h912;
    run_frame(10, -1, 12'h000);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midreset_joy_data", 32'(JOY_DATA), 32'd1);
    check("midreset_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_reset_joy_data", 32'(JOY_DATA), 32'd1);
    run_frame(FRAME_BITS, -1, 12'h000);

    repeat (10) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("fd_q_drained", 32'(fd_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/joy_db15_tx.md
# joy_db15_tx

Device-side model of the DB15 joystick adapter: a synchronised, 74HC165-style parallel-in/serial-out responder. The host drives JOY_LOAD and JOY_CLK; this block answers on JOY_DATA with a 24-bit active-low frame built from two 12-bit joystick words. It is the other end of the link read by `joy_db15`. It serves as the loopback/bench partner for that receiver and as the FPGA-side emulation of the adapter when a core re-exports pad state over the user port.

## Interface

Parameters:
- `SYNC_STAGES`, default 2: flip-flop stages on JOY_CLK and JOY_LOAD; legal range 2..4.
- `PLAYER_BITS`, default 12: bits per player. Word layout, MSB to LSB, is L S F E D C B A U D L R.

Ports:
- `clk`  in  1: single clock, 40–50 MHz.
- `reset_n`  in  1: asynchronous, active-low reset.
- `joy_p1`  in  PLAYER_BITS: player 1 buttons, active-high, `clk` domain.
- `joy_p2`  in  PLAYER_BITS: player 2 buttons, active-high, `clk` domain.
- `JOY_CLK`  in  1: host shift clock, asynchronous to `clk`.
- `JOY_LOAD`  in  1: host load strobe, active-low, asynchronous to `clk`.
- `JOY_DATA`  out  1: serial data, active-low (0 = pressed). Registered.
- `frame_done`  out  1: one-`clk` pulse when the 2·PLAYER_BITS-th shift edge is taken.
- `busy`  out  1: high while shift count is in 1..2·PLAYER_BITS−1.

## Operation

- Only one clock and one reset are decided: `clk`, plus `reset_n` (asynchronous, active-low).
- Synchroniser reset values: JOY_CLK chain resets to 1; JOY_LOAD chain resets to 1.
  - Consequence: a host clock already high at reset release produces no spurious rising edge.
- `ld` is the synchronised JOY_LOAD. `ck_rise` is a one-cycle pulse when synchronised JOY_CLK goes 0→1. Falling edges are ignored.
- Shift register `sr[2N−1:0]`, N = PLAYER_BITS. `JOY_DATA` register = `sr[0]`.
- Bit counter `cnt`, width clog2(2N+1), saturates at 2N.
- Priority per `clk` cycle, highest first:
  1. `ld == 0`: `sr <= {~joy_p2, ~joy_p1}`, `cnt <= 0`. Any coincident `ck_rise` is ignored, because load is level-sensitive and wins.
  2. `ck_rise`: `sr <= {1'b1, sr[2N−1:1]}`. `cnt <= cnt+1` unless already 2N.
  3. Otherwise: hold.
- Wire order after load: P1 bit0 (R) first, through P1 bit11, then P2 bit0 through P2 bit11, all inverted.
- Overrun: shifts beyond 2N emit 1 (released), as with a 165 whose SER pin is tied high. `cnt` stays at 2N and there is no further `frame_done`.
- `frame_done` = registered (`ck_rise` & `ld` & `cnt == 2N−1`).
- `busy` = registered (`cnt != 0 && cnt != 2N`).
- `joy_p1`/`joy_p2` are sampled only on load cycles. Changes during shifting do not alter the frame in flight.
- JOY_LOAD held low continuously: `JOY_DATA` tracks `~joy_p1[0]` with 1-cycle register latency.

## Timing

- Reset values: `JOY_DATA`=1, `sr`=all 1, `cnt`=0, `frame_done`=0, `busy`=0.
- Latency from a JOY_LOAD falling edge to `JOY_DATA` valid with the new bit0: SYNC_STAGES+1 `clk` cycles.
- Latency from a JOY_CLK rising edge to the next bit on `JOY_DATA`: SYNC_STAGES+2 `clk` cycles. This is detect plus register.
- Host requirements:
  - JOY_CLK high and low phases each ≥ SYNC_STAGES+3 `clk` cycles.
  - Host samples JOY_DATA no earlier than SYNC_STAGES+2 cycles after its clock edge.
  - JOY_LOAD low pulse ≥ SYNC_STAGES+1 cycles.
- Narrower pulses may be missed. Behaviour is undefined, but the block must never hang: the next valid load recovers fully.
- JOY_LOAD deassertion and a JOY_CLK rise in the same synchronised cycle: load wins for that cycle. The edge is consumed and no shift occurs.
- `reset_n` asserted mid-frame: all state returns to reset values immediately (asynchronously). The frame resumes only after a new load.

## Test plan

- Reset, then host idle (CLK=0, LOAD=1): `JOY_DATA`=1, `busy`=0, no `frame_done` for 1000 cycles.
- `joy_p1`=12'h001, `joy_p2`=12'h800, one load plus 24 clocks at 8-cycle half-period. Wire sequence: 0, 1×22, 0. Exactly one `frame_done`, aligned with the 24th edge.
- Same frame with `joy_p1` changed to 12'hFFF after the 3rd clock: captured bits still match 12'h001.
- 30 clocks after a single load: bits 25–30 all 1. One `frame_done` only. `cnt` stays at 24.
- JOY_LOAD held low while JOY_CLK toggles 10 times: `JOY_DATA` stays at `~joy_p1[0]`, no shifts, `busy`=0.
- `reset_n` pulsed low after 10 shifts: `JOY_DATA`=1 during reset. The next load plus 24 clocks returns the full, correct frame.
